// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB with unconditional tagging, gshare/bimodal PHT,
// non-speculative global history and saturating performance counters.
module branch_predictor #(
  parameter int unsigned GHR_BITS       = 5,
  parameter int unsigned BTB_INDEX_BITS = 5,
  parameter int unsigned MODE           = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic [31:0] predicted_pc,
  output logic        predicted_taken,
  input  logic        stall,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam int unsigned BTB_DEPTH  = 1 << BTB_INDEX_BITS;
  localparam int unsigned PHT_DEPTH  = 1 << GHR_BITS;
  localparam int unsigned TAG_W      = 32 - BTB_INDEX_BITS - 2;
  localparam bit          USE_TABLES = (MODE != 2);
  localparam bit          USE_GHR    = (MODE == 0);

  logic                      r_btb_valid  [BTB_DEPTH];
  logic                      r_btb_uncond [BTB_DEPTH];
  logic [TAG_W-1:0]          r_btb_tag    [BTB_DEPTH];
  logic [31:0]               r_btb_target [BTB_DEPTH];
  logic [1:0]                r_pht        [PHT_DEPTH];
  logic [GHR_BITS-1:0]       r_ghr;

  logic [BTB_INDEX_BITS-1:0] w_lk_bidx;
  logic [TAG_W-1:0]          w_lk_tag;
  logic [GHR_BITS-1:0]       w_lk_pidx;
  logic                      w_lk_hit;
  logic                      w_lk_taken;

  logic [BTB_INDEX_BITS-1:0] w_up_bidx;
  logic [TAG_W-1:0]          w_up_tag;
  logic [GHR_BITS-1:0]       w_up_pidx;
  logic [1:0]                w_pht_cur;
  logic [1:0]                w_pht_next;
  logic                      w_accept;
  logic                      w_unused;

  assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup path: purely combinational on if_pc and current table state
  always_comb begin
    w_lk_bidx = if_pc[BTB_INDEX_BITS+1:2];
    w_lk_tag  = if_pc[31:BTB_INDEX_BITS+2];
    w_lk_pidx = if_pc[GHR_BITS+1:2];
    if (USE_GHR) w_lk_pidx = w_lk_pidx ^ r_ghr;
    w_lk_hit   = r_btb_valid[w_lk_bidx] && (r_btb_tag[w_lk_bidx] == w_lk_tag);
    w_lk_taken = USE_TABLES && !reset && w_lk_hit &&
                 (r_btb_uncond[w_lk_bidx] || r_pht[w_lk_pidx][1]);
    predicted_taken = w_lk_taken;
    predicted_pc    = w_lk_taken ? r_btb_target[w_lk_bidx] : (if_pc + 32'd4);
  end

  // Training-side indices and the saturated counter value to write back
  always_comb begin
    w_accept  = upd_valid && !stall;
    w_up_bidx = upd_pc[BTB_INDEX_BITS+1:2];
    w_up_tag  = upd_pc[31:BTB_INDEX_BITS+2];
    w_up_pidx = upd_pc[GHR_BITS+1:2];
    if (USE_GHR) w_up_pidx = w_up_pidx ^ r_ghr;
    w_pht_cur  = r_pht[w_up_pidx];
    w_pht_next = w_pht_cur;
    if (upd_taken && (w_pht_cur != 2'b11))
      w_pht_next = w_pht_cur + 2'd1;
    else if (!upd_taken && (w_pht_cur != 2'b00))
      w_pht_next = w_pht_cur - 2'd1;
  end

  // Reset wins over a same-cycle update; stall suppresses everything
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        r_btb_valid[BTB_INDEX_BITS'(i)]  <= 1'b0;
        r_btb_uncond[BTB_INDEX_BITS'(i)] <= 1'b0;
        r_btb_tag[BTB_INDEX_BITS'(i)]    <= '0;
        r_btb_target[BTB_INDEX_BITS'(i)] <= 32'd0;
      end
      for (int unsigned i = 0; i < PHT_DEPTH; i++) begin
        r_pht[GHR_BITS'(i)] <= 2'b01;
      end
      r_ghr            <= '0;
      perf_branches    <= 32'd0;
      perf_mispredicts <= 32'd0;
    end else if (w_accept) begin
      if (upd_is_branch && (perf_branches != 32'hFFFF_FFFF))
        perf_branches <= perf_branches + 32'd1;
      if (upd_mispredict && (perf_mispredicts != 32'hFFFF_FFFF))
        perf_mispredicts <= perf_mispredicts + 32'd1;
      if (USE_TABLES) begin
        if (upd_taken) begin
          r_btb_valid[w_up_bidx]  <= 1'b1;
          r_btb_uncond[w_up_bidx] <= !upd_is_branch;
          r_btb_tag[w_up_bidx]    <= w_up_tag;
          r_btb_target[w_up_bidx] <= upd_target;
        end
        if (upd_is_branch) begin
          r_pht[w_up_pidx] <= w_pht_next;
          r_ghr            <= GHR_BITS'({r_ghr, upd_taken});
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench: gshare, bimodal and static instances share
// stimulus and are each compared against an array-based reference model.
module tb_branch_predictor;

  localparam int NI = 3;
  localparam int MD [NI] = '{0, 1, 2};
  localparam int GB [NI] = '{2, 5, 5};
  localparam int BB = 5;

  logic        clk;
  logic        reset, stall, upd_valid, upd_is_branch, upd_taken, upd_mispredict;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic [31:0] pp [NI];
  logic [31:0] pb [NI];
  logic [31:0] pm [NI];
  logic        pt [NI];

  branch_predictor #(.GHR_BITS(2), .BTB_INDEX_BITS(BB), .MODE(0)) u_gs (
    .clk(clk), .reset(reset), .if_pc(if_pc), .predicted_pc(pp[0]), .predicted_taken(pt[0]),
    .stall(stall), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_branches(pb[0]), .perf_mispredicts(pm[0]));

  branch_predictor #(.GHR_BITS(5), .BTB_INDEX_BITS(BB), .MODE(1)) u_bi (
    .clk(clk), .reset(reset), .if_pc(if_pc), .predicted_pc(pp[1]), .predicted_taken(pt[1]),
    .stall(stall), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_branches(pb[1]), .perf_mispredicts(pm[1]));

  branch_predictor #(.GHR_BITS(5), .BTB_INDEX_BITS(BB), .MODE(2)) u_st (
    .clk(clk), .reset(reset), .if_pc(if_pc), .predicted_pc(pp[2]), .predicted_taken(pt[2]),
    .stall(stall), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_branches(pb[2]), .perf_mispredicts(pm[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          mv   [NI][32];
  bit          mun  [NI][32];
  int unsigned mtag [NI][32];
  logic [31:0] mtgt [NI][32];
  int          mpht [NI][4096];
  int unsigned mghr [NI];
  logic [31:0] mbr  [NI];
  logic [31:0] mmp  [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int m_bidx(input logic [31:0] pc);
    return int'((pc / 4) % 32);
  endfunction

  function automatic bit m_taken(input int k, input logic [31:0] pc);
    int          b;
    int unsigned p;
    b = m_bidx(pc);
    p = (pc / 4) % (32'd1 << GB[k]);
    if (MD[k] == 0) p = p ^ mghr[k];
    if (MD[k] == 2 || reset) return 1'b0;
    return mv[k][b] && (mtag[k][b] == pc / 128) && (mun[k][b] || mpht[k][p] >= 2);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 32; i++) begin
        mv[k][i] = 1'b0; mun[k][i] = 1'b0; mtag[k][i] = 0; mtgt[k][i] = 32'd0;
      end
      for (int i = 0; i < 4096; i++) mpht[k][i] = 1;
      mghr[k] = 0; mbr[k] = 32'd0; mmp[k] = 32'd0;
    end
  endtask

  // Apply the clock-edge rules to the model using the currently driven inputs
  task automatic m_edge();
    int          b;
    int unsigned p;
    if (reset) begin
      m_reset();
      return;
    end
    if (!upd_valid || stall) return;
    for (int k = 0; k < NI; k++) begin
      if (upd_is_branch && mbr[k] != 32'hFFFF_FFFF) mbr[k] = mbr[k] + 1;
      if (upd_mispredict && mmp[k] != 32'hFFFF_FFFF) mmp[k] = mmp[k] + 1;
      if (MD[k] != 2) begin
        b = m_bidx(upd_pc);
        if (upd_taken) begin
          mv[k][b] = 1'b1; mun[k][b] = !upd_is_branch;
          mtag[k][b] = upd_pc / 128; mtgt[k][b] = upd_target;
        end
        if (upd_is_branch) begin
          p = (upd_pc / 4) % (32'd1 << GB[k]);
          if (MD[k] == 0) p = p ^ mghr[k];
          if (upd_taken) mpht[k][p] = (mpht[k][p] == 3) ? 3 : mpht[k][p] + 1;
          else           mpht[k][p] = (mpht[k][p] == 0) ? 0 : mpht[k][p] - 1;
          mghr[k] = ((mghr[k] * 2) + (upd_taken ? 1 : 0)) % (32'd1 << GB[k]);
        end
      end
    end
  endtask

  // Check outputs mid-cycle, then advance one edge in DUT and model together
  task automatic tick();
    bit          tk;
    logic [31:0] epc;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tk  = m_taken(k, if_pc);
      epc = tk ? mtgt[k][m_bidx(if_pc)] : (if_pc + 32'd4);
      check($sformatf("m%0d pred_pc pc=%08h", MD[k], if_pc), pp[k], epc);
      check($sformatf("m%0d pred_taken pc=%08h", MD[k], if_pc), 32'(pt[k]), 32'(tk));
      check($sformatf("m%0d perf_branches", MD[k]), pb[k], mbr[k]);
      check($sformatf("m%0d perf_mispredicts", MD[k]), pm[k], mmp[k]);
    end
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic br,
                         input logic tk, input logic [31:0] tgt, input logic mp);
    upd_valid = v; upd_pc = pc; upd_is_branch = br;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 15) == 0) pc = $urandom & 32'hFFFF_FFFC;
    else pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 2);
    return pc;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; if_pc = 32'h40;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    m_edge();
    #1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // jal allocation, then tag-aliased lookup and pc wrap
    set_upd(1'b1, 32'h10, 1'b0, 1'b1, 32'h80, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h10; tick();
    check("ghr after jal", 32'(u_gs.r_ghr), mghr[0]);
    if_pc = 32'h90; tick();
    if_pc = 32'hFFFF_FFFC; tick();

    // branch training: T, T, N, N with lookups in between
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 32'h20, 1'b1, (i < 2), 32'h8, 1'b0);
      if_pc = 32'h20; tick();
      set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end

    // stall blocks update, then reset beats update
    stall = 1'b1;
    set_upd(1'b1, 32'h30, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    stall = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h30; tick();
    reset = 1'b1;
    set_upd(1'b1, 32'h30, 1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    if_pc = 32'h10; tick();

    // global history shifting: T, N, T
    for (int i = 0; i < 3; i++) begin
      set_upd(1'b1, 32'h44, 1'b1, (i != 1), 32'h200, 1'b0);
      tick();
      check($sformatf("ghr step %0d", i), 32'(u_gs.r_ghr), mghr[0]);
    end

    // mispredict counter saturation
    force u_gs.perf_mispredicts = 32'hFFFF_FFFD;
    #1;
    release u_gs.perf_mispredicts;
    mmp[0] = 32'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      set_upd(1'b1, 32'h48, 1'b0, 1'b1, 32'h300, 1'b1);
      tick();
    end
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      if_pc = rand_pc();
      set_upd($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
